branch_predict_btb: RTL and testbench

//  Parametrised branch target buffer + 2-bit saturating direction predictor for the pipelined core.

---
 rtl/branch_predict_btb.sv | 150 +++++++++++++++
 tb/tb_branch_predict_btb.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Optional statistics counters are enabled by defining BTB_STATS_EN.
module branch_predict_btb #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CTR_W   = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] fetch_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
`ifdef BTB_STATS_EN
    ,
    input  logic        stat_clr,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_updates,
    output logic [31:0] stat_mispred
`endif
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

    // Entry storage; only the valid bits are reset.
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];

    // Fetch-side lookup, purely combinational.
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;

    assign f_idx = fetch_pc[IDX_W+1:2];
    assign f_tag = fetch_pc[31:IDX_W+2];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    assign pred_hit    = f_hit;
    assign pred_taken  = f_hit && ctr_q[f_idx][CTR_W-1];
    assign pred_target = f_hit ? target_q[f_idx] : 32'h0;

    // Update-side decode of the resolved branch.
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic [CTR_W-1:0] u_ctr;

    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[31:IDX_W+2];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign u_ctr = ctr_q[u_idx];

    logic             alloc;
    logic             ctr_we;
    logic             tgt_we;
    logic [CTR_W-1:0] ctr_nxt;

    // Counter/target/allocation decisions for this cycle's update.
    always_comb begin
        alloc   = 1'b0;
        ctr_we  = 1'b0;
        tgt_we  = 1'b0;
        ctr_nxt = u_ctr;
        if (upd_valid) begin
            if (u_hit) begin
                ctr_we = 1'b1;
                if (upd_taken) begin
                    tgt_we = 1'b1;
                    if (u_ctr != CTR_MAX) begin
                        ctr_nxt = u_ctr + CTR_W'(1);
                    end
                end else if (u_ctr != '0) begin
                    ctr_nxt = u_ctr - CTR_W'(1);
                end
            end else if (upd_taken) begin
                alloc   = 1'b1;
                ctr_we  = 1'b1;
                tgt_we  = 1'b1;
                ctr_nxt = CTR_WEAK;
            end
        end
    end

    // Valid bits drop asynchronously so predictions vanish the moment reset asserts.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
        end else if (alloc) begin
            valid_q[u_idx] <= 1'b1;
        end
    end

    // Payload arrays carry no reset; writes are suppressed while reset is held.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            if (alloc) begin
                tag_q[u_idx] <= u_tag;
            end
            if (tgt_we) begin
                target_q[u_idx] <= upd_target;
            end
            if (ctr_we) begin
                ctr_q[u_idx] <= ctr_nxt;
            end
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

`ifdef BTB_STATS_EN
    logic u_pred;
    logic mispred;

    assign u_pred  = u_hit && u_ctr[CTR_W-1];
    assign mispred = upd_valid && (u_pred != upd_taken);

    // Saturating event counters; a synchronous clear beats a same-cycle increment.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_lookups <= 32'h0;
            stat_updates <= 32'h0;
            stat_mispred <= 32'h0;
        end else if (stat_clr) begin
            stat_lookups <= 32'h0;
            stat_updates <= 32'h0;
            stat_mispred <= 32'h0;
        end else begin
            if (stat_lookups != 32'hFFFF_FFFF) begin
                stat_lookups <= stat_lookups + 32'd1;
            end
            if (upd_valid && (stat_updates != 32'hFFFF_FFFF)) begin
                stat_updates <= stat_updates + 32'd1;
            end
            if (mispred && (stat_mispred != 32'hFFFF_FFFF)) begin
                stat_mispred <= stat_mispred + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_btb.sv
// Scoreboard bench for branch_predict_btb: stimulus queues expected lookups, a monitor compares them.
module tb_branch_predict_btb;

    logic        CLK;
    logic        nRST;
    logic [31:0] fetch_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
`ifdef BTB_STATS_EN
    logic        stat_clr;
    logic [31:0] stat_lookups;
    logic [31:0] stat_updates;
    logic [31:0] stat_mispred;
    logic        stat_chk;
    logic [31:0] exp_look;
    logic [31:0] exp_upd;
    logic [31:0] exp_mis;
`endif

    branch_predict_btb dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .fetch_pc    (fetch_pc),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target)
`ifdef BTB_STATS_EN
        ,
        .stat_clr     (stat_clr),
        .stat_lookups (stat_lookups),
        .stat_updates (stat_updates),
        .stat_mispred (stat_mispred)
`endif
    );

    typedef struct packed {
        logic        hit;
        logic        taken;
        logic [31:0] target;
        logic [7:0]  id;
    } exp_t;

    exp_t sb[$];
    logic chk;
    int   n_cmp;
    int   n_fail;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Monitor: compares the DUT lookup against the oldest expectation whenever a check is flagged.
    always @(negedge CLK) begin
        if (chk) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_empty: check strobe with no expectation queued");
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_cmp++;
                if (pred_hit !== e.hit) begin
                    n_fail++;
                    $display("FAIL hit[%0d]: got %b want %b", e.id, pred_hit, e.hit);
                end
                n_cmp++;
                if (pred_taken !== e.taken) begin
                    n_fail++;
                    $display("FAIL taken[%0d]: got %b want %b", e.id, pred_taken, e.taken);
                end
                n_cmp++;
                if (pred_target !== e.target) begin
                    n_fail++;
                    $display("FAIL target[%0d]: got %h want %h", e.id, pred_target, e.target);
                end
            end
        end
`ifdef BTB_STATS_EN
        if (stat_chk) begin
            n_cmp++;
            if (stat_lookups !== exp_look) begin
                n_fail++;
                $display("FAIL stat_lookups: got %0d want %0d", stat_lookups, exp_look);
            end
            n_cmp++;
            if (stat_updates !== exp_upd) begin
                n_fail++;
                $display("FAIL stat_updates: got %0d want %0d", stat_updates, exp_upd);
            end
            n_cmp++;
            if (stat_mispred !== exp_mis) begin
                n_fail++;
                $display("FAIL stat_mispred: got %0d want %0d", stat_mispred, exp_mis);
            end
        end
`endif
    end

    // One cycle of stimulus, driven just after the rising edge.
    task automatic cyc(input logic [31:0] fpc, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic c,
                       input logic eh, input logic et, input logic [31:0] etgt, input int id);
        exp_t e;
        @(posedge CLK);
        #1;
        fetch_pc   = fpc;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_taken  = ut;
        upd_target = utgt;
        chk        = c;
        if (c) begin
            e.hit    = eh;
            e.taken  = et;
            e.target = etgt;
            e.id     = 8'(id);
            sb.push_back(e);
        end
    endtask

    task automatic look(input logic [31:0] pc, input logic eh, input logic et,
                        input logic [31:0] etgt, input int id);
        cyc(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, eh, et, etgt, id);
    endtask

    task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        cyc(32'h0, 1'b1, pc, t, tgt, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    endtask

    initial begin
        int guard;
        n_cmp      = 0;
        n_fail     = 0;
        chk        = 1'b0;
        nRST       = 1'b0;
        fetch_pc   = 32'h0;
        upd_valid  = 1'b0;
        upd_pc     = 32'h0;
        upd_taken  = 1'b0;
        upd_target = 32'h0;
`ifdef BTB_STATS_EN
        stat_clr = 1'b0;
        stat_chk = 1'b0;
        exp_look = 32'h0;
        exp_upd  = 32'h0;
        exp_mis  = 32'h0;
`endif
        // Reset: predictions must be zero while held.
        cyc(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        look(32'h40, 1'b0, 1'b0, 32'h0, 1);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        chk  = 1'b0;

        // Allocation on taken miss, weakly taken.
        upd(32'h40, 1'b1, 32'h100);
        look(32'h40, 1'b1, 1'b1, 32'h100, 2);

        // Hysteresis: 10 -> 01 -> 10 -> 11 -> 10.
        upd(32'h40, 1'b0, 32'h0);
        look(32'h40, 1'b1, 1'b0, 32'h100, 3);
        upd(32'h40, 1'b1, 32'h100);
        upd(32'h40, 1'b1, 32'h100);
        look(32'h40, 1'b1, 1'b1, 32'h100, 4);
        upd(32'h40, 1'b0, 32'h0);
        look(32'h40, 1'b1, 1'b1, 32'h100, 5);

        // Saturation at 0 and at 3; last taken update moves the target.
        for (int i = 0; i < 5; i++) upd(32'h40, 1'b0, 32'h0);
        look(32'h40, 1'b1, 1'b0, 32'h100, 6);
        for (int i = 0; i < 4; i++) upd(32'h40, 1'b1, 32'h100);
        upd(32'h40, 1'b1, 32'h108);
        look(32'h40, 1'b1, 1'b1, 32'h108, 7);
        upd(32'h40, 1'b0, 32'h0);
        look(32'h40, 1'b1, 1'b1, 32'h108, 8);
        upd(32'h40, 1'b0, 32'h0);
        look(32'h40, 1'b1, 1'b0, 32'h108, 9);

        // Not-taken miss does not allocate; low PC bits are ignored.
        upd(32'h48, 1'b0, 32'h200);
        look(32'h48, 1'b0, 1'b0, 32'h0, 10);
        look(32'h43, 1'b1, 1'b0, 32'h108, 11);

        // Tag conflict on index 0: newer taken branch evicts.
        upd(32'h80, 1'b1, 32'h300);
        look(32'h40, 1'b0, 1'b0, 32'h0, 12);
        look(32'h80, 1'b1, 1'b1, 32'h300, 13);

        // Same-cycle lookup and update: old contents seen first.
        cyc(32'h44, 1'b1, 32'h44, 1'b1, 32'h500, 1'b1, 1'b0, 1'b0, 32'h0, 14);
        look(32'h44, 1'b1, 1'b1, 32'h500, 15);

        // upd_valid low leaves storage untouched.
        cyc(32'h80, 1'b0, 32'h80, 1'b1, 32'hDEAD, 1'b1, 1'b1, 1'b1, 32'h300, 16);
        look(32'h80, 1'b1, 1'b1, 32'h300, 17);

        // Mid-run async reset: outputs drop before the next clock edge.
        @(posedge CLK);
        #1;
        chk      = 1'b1;
        nRST     = 1'b0;
        fetch_pc = 32'h80;
        upd_valid = 1'b0;
        sb.push_back('{hit: 1'b0, taken: 1'b0, target: 32'h0, id: 8'd18});
        @(posedge CLK);
        #1;
        chk  = 1'b0;
        nRST = 1'b1;
        look(32'h80, 1'b0, 1'b0, 32'h0, 19);
        look(32'h44, 1'b0, 1'b0, 32'h0, 20);

`ifdef BTB_STATS_EN
        // Clear, then three updates on 0x80 with exactly one mispredict (the first).
        @(posedge CLK);
        #1;
        chk      = 1'b0;
        stat_clr = 1'b1;
        @(posedge CLK);
        #1;
        stat_clr = 1'b0;
        exp_look = 32'h0;
        exp_upd  = 32'h0;
        exp_mis  = 32'h0;
        stat_chk = 1'b1;
        upd_valid  = 1'b1;
        upd_pc     = 32'h80;
        upd_taken  = 1'b1;
        upd_target = 32'h300;
        @(posedge CLK);
        #1;
        stat_chk = 1'b0;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        upd_valid = 1'b0;
        exp_look  = 32'd3;
        exp_upd   = 32'd3;
        exp_mis   = 32'd1;
        stat_chk  = 1'b1;
        @(posedge CLK);
        #1;
        stat_chk = 1'b0;
        stat_clr = 1'b1;
        upd_valid = 1'b1;
        @(posedge CLK);
        #1;
        stat_clr  = 1'b0;
        upd_valid = 1'b0;
        exp_look  = 32'h0;
        exp_upd   = 32'h0;
        exp_mis   = 32'h0;
        stat_chk  = 1'b1;
        @(posedge CLK);
        #1;
        stat_chk = 1'b0;
`endif

        cyc(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            @(posedge CLK);
            guard++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
